// File: rtl/fmap_feeder.sv
// fmap_feeder: loads one W x H feature map from a ready/valid stream into a
// frame buffer, then replays it PASSES times as a zero-padded (W+2) x (H+2)
// raster, one pixel per clock, for the convolution engine.
//
// Handshake: s_data is accepted on a rising edge where s_valid and s_ready are
// both high; s_ready depends only on the FSM state (high only in LOAD), never
// on s_valid. The output side has no backpressure: every cycle valid_out is
// high carries one pixel that must be consumed.
module fmap_feeder #(
    parameter int M      = 8,
    parameter int W      = 480,
    parameter int H      = 480,
    parameter int PASSES = 4,
    parameter int GAP    = 2
) (
    input  logic         clk,
    input  logic         Rst_n,
    input  logic         start,
    input  logic [M-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [M-1:0] dout,
    output logic         valid_out,
    output logic         repeat_out,
    output logic         busy,
    output logic         frame_done
);

    localparam int DEPTH = W * H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(W + 2);
    localparam int RW    = $clog2(H + 2);
    localparam int PW    = $clog2(PASSES + 1);
    localparam int GW    = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] C_LAST = CW'(W + 1);
    localparam logic [RW-1:0] R_LAST = RW'(H + 1);
    localparam logic [PW-1:0] P_LAST = PW'(PASSES);
    localparam logic [GW-1:0] G_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Current FSM state; kept as a named signal so checkers can bind to it.
    state_t state;
    state_t state_nxt;

    logic [M-1:0]  mem [DEPTH];
    logic [M-1:0]  rd_data;

    logic [AW-1:0] ld_addr;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] c;
    logic [RW-1:0] r;
    logic [PW-1:0] pass_cnt;
    logic [GW-1:0] gap_cnt;

    // Stage 1: address / pad register. Stage 2: memory read / output register.
    logic          s1_valid, s1_pad, s1_rep, s1_last;
    logic [AW-1:0] s1_raddr;
    logic          s2_valid, s2_pad, s2_rep, s2_last;

    logic accept, load_last, sending, interior, cell_last, pass_last, gap_last;

    assign accept    = (state == ST_LOAD) && s_valid;
    assign load_last = accept && (ld_addr == A_LAST);
    assign sending   = (state == ST_SEND);
    assign interior  = (r != '0) && (r != R_LAST) && (c != '0) && (c != C_LAST);
    assign cell_last = sending && (r == R_LAST) && (c == C_LAST);
    assign pass_last = (pass_cnt == P_LAST);
    assign gap_last  = (gap_cnt == G_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!Rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. DONE holds until the final beat has left the output
    // pipeline so that frame_done and the fall of busy line up with it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: if (load_last) state_nxt = ST_SEND;
            ST_SEND: begin
                if (cell_last) begin
                    if (pass_last)     state_nxt = ST_DONE;
                    else if (GAP == 0) state_nxt = ST_SEND;
                    else               state_nxt = ST_GAP;
                end
            end
            ST_GAP:  if (gap_last) state_nxt = ST_SEND;
            ST_DONE: if (s2_valid && s2_last) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Load address, raster counters, pass and gap counters. The buffer read
    // address advances only on interior cells, which yields (r-1)*W+(c-1)
    // without a multiplier.
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            ld_addr  <= '0;
            rd_addr  <= '0;
            c        <= '0;
            r        <= '0;
            pass_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (state == ST_IDLE) ld_addr <= '0;
            else if (accept)      ld_addr <= load_last ? '0 : ld_addr + AW'(1);

            if (load_last) pass_cnt <= PW'(1);
            else if (cell_last && !pass_last) pass_cnt <= pass_cnt + PW'(1);

            if (sending) begin
                if (c == C_LAST) begin
                    c <= '0;
                    r <= (r == R_LAST) ? '0 : r + RW'(1);
                end else begin
                    c <= c + CW'(1);
                end
                if (cell_last)     rd_addr <= '0;
                else if (interior) rd_addr <= rd_addr + AW'(1);
            end

            if (state == ST_GAP) gap_cnt <= gap_last ? '0 : gap_cnt + GW'(1);
            else                 gap_cnt <= '0;
        end
    end

    // Output pipeline control (valid, pad, repeat, last-beat tags) and frame_done.
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            s1_valid   <= 1'b0;
            s1_pad     <= 1'b0;
            s1_rep     <= 1'b0;
            s1_last    <= 1'b0;
            s1_raddr   <= '0;
            s2_valid   <= 1'b0;
            s2_pad     <= 1'b0;
            s2_rep     <= 1'b0;
            s2_last    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            s1_valid   <= sending;
            s1_pad     <= !interior;
            s1_rep     <= sending && (pass_cnt != PW'(1));
            s1_last    <= cell_last && pass_last;
            s1_raddr   <= rd_addr;
            s2_valid   <= s1_valid;
            s2_pad     <= s1_pad;
            s2_rep     <= s1_rep;
            s2_last    <= s1_valid && s1_last;
            frame_done <= (state == ST_DONE) && s2_valid && s2_last;
        end
    end

    // Frame buffer: write on load handshake, registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept) mem[ld_addr] <= s_data;
        rd_data <= mem[s1_raddr];
    end

    assign s_ready    = (state == ST_LOAD);
    assign busy       = (state != ST_IDLE);
    assign valid_out  = s2_valid;
    assign repeat_out = s2_valid && s2_rep;
    assign dout       = (s2_valid && !s2_pad) ? rd_data : '0;

endmodule

// File: tb/tb_fmap_feeder.sv
// Directed bench for fmap_feeder: a 4x3 map replayed twice with a 2-cycle gap,
// plus a 1x1 single-pass instance.
module tb_fmap_feeder;

    logic       clk = 1'b0;
    logic       Rst_n;
    logic       start, s_valid, s_ready;
    logic [7:0] s_data, dout;
    logic       valid_out, repeat_out, busy, frame_done;

    logic       b_start, b_s_valid, b_s_ready;
    logic [7:0] b_s_data, b_dout;
    logic       b_valid_out, b_repeat_out, b_busy, b_frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] exp_q[$];
    logic [7:0]  pix[30] = '{0, 0, 0, 0, 0, 0,
                             0, 1, 2, 3, 4, 0,
                             0, 5, 6, 7, 8, 0,
                             0, 9, 10, 11, 12, 0,
                             0, 0, 0, 0, 0, 0};

    fmap_feeder #(.M(8), .W(4), .H(3), .PASSES(2), .GAP(2)) dut_a (
        .clk(clk), .Rst_n(Rst_n), .start(start), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready), .dout(dout),
        .valid_out(valid_out), .repeat_out(repeat_out), .busy(busy),
        .frame_done(frame_done));

    fmap_feeder #(.M(8), .W(1), .H(1), .PASSES(1), .GAP(0)) dut_b (
        .clk(clk), .Rst_n(Rst_n), .start(b_start), .s_data(b_s_data),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .dout(b_dout),
        .valid_out(b_valid_out), .repeat_out(b_repeat_out), .busy(b_busy),
        .frame_done(b_frame_done));

    // clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected per-cycle {valid, repeat, frame_done, busy, dout} from the
    // negedge right after the last load pixel is accepted.
    task automatic build_exp_a();
        exp_q.delete();
        repeat (2) exp_q.push_back({4'b0001, 8'h00});
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 30; i++) exp_q.push_back({1'b1, p[0], 2'b01, pix[i]});
            if (p == 0) repeat (2) exp_q.push_back({4'b0001, 8'h00});
        end
        exp_q.push_back({4'b0010, 8'h00});
        exp_q.push_back({4'b0000, 8'h00});
    endtask

    // Start a load and stream pixels 1..12; returns at the negedge after the
    // last accept. With rand_valid, s_valid toggles and idle cycles carry junk.
    task automatic load_a(input bit rand_valid);
        int idx = 1;
        int guard = 0;
        bit v;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (idx <= 12 && guard < 200) begin
            check("s_ready_load", 32'(s_ready), 32'd1);
            v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_valid = v;
            s_data  = v ? 8'(idx) : 8'($urandom_range(200, 255));
            if (v) idx++;
            guard++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_data  = 8'h00;
        if (idx <= 12) check("load_timeout", 32'(idx), 32'd13);
    endtask

    task automatic capture_a(input int ncyc, input int start_k, input int reset_k);
        logic [11:0] obs;
        for (int k = 0; k < ncyc; k++) begin
            obs = {valid_out, repeat_out, frame_done, busy, dout};
            check($sformatf("frame_a[%0d]", k), 32'(obs), 32'(exp_q.pop_front()));
            check($sformatf("s_ready_send[%0d]", k), 32'(s_ready), 32'd0);
            start = (k == start_k) || (k == start_k + 30);
            if (k == reset_k) Rst_n = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        logic [11:0] obs;
        logic [11:0] expv;
        Rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        b_start = 1'b0; b_s_valid = 1'b0; b_s_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_a", 32'({valid_out, repeat_out, frame_done, busy, dout, s_ready}), 32'd0);
        check("reset_b", 32'({b_valid_out, b_repeat_out, b_frame_done, b_busy, b_dout, b_s_ready}), 32'd0);
        Rst_n = 1'b1;
        @(negedge clk);

        // 1+2: full load, two passes with gap, frame_done and busy fall
        load_a(1'b0);
        build_exp_a();
        capture_a(66, -1, -1);

        // 3+4: random s_valid during load, start pulses during SEND ignored
        load_a(1'b1);
        build_exp_a();
        capture_a(66, 10, -1);

        // 5: reset at beat 15 of pass 1, then a clean rerun
        load_a(1'b0);
        build_exp_a();
        capture_a(17, -1, 16);
        check("mid_reset_a", 32'({valid_out, repeat_out, frame_done, busy, dout, s_ready}), 32'd0);
        Rst_n = 1'b1;
        @(negedge clk);
        load_a(1'b0);
        build_exp_a();
        capture_a(66, -1, -1);

        // 6: 1x1 map, one pass, no gap
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        check("b_s_ready_load", 32'(b_s_ready), 32'd1);
        b_s_valid = 1'b1;
        b_s_data  = 8'hAB;
        @(negedge clk);
        b_s_valid = 1'b0;
        b_s_data  = 8'h00;
        for (int k = 0; k < 13; k++) begin
            if (k < 2)        expv = {4'b0001, 8'h00};
            else if (k <= 10) expv = {4'b1001, (k == 6) ? 8'hAB : 8'h00};
            else if (k == 11) expv = {4'b0010, 8'h00};
            else              expv = {4'b0000, 8'h00};
            obs = {b_valid_out, b_repeat_out, b_frame_done, b_busy, b_dout};
            check($sformatf("frame_b[%0d]", k), 32'(obs), 32'(expv));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
